// File: rtl/section_peak_to_peak.sv
// Multi-channel peak-to-peak (max - min) detector over sections of sample_count samples per channel.
// Define SECTION_PEAK_TO_PEAK_SIGNED_EN to treat samples as two's complement; unsigned otherwise.
module section_peak_to_peak #(
    parameter int unsigned width        = 16,
    parameter int unsigned sample_count = 3,
    parameter int unsigned channels     = 2,
    localparam int unsigned CW = (channels > 1) ? $clog2(channels) : 1,
    localparam int unsigned NW = $clog2(sample_count + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [width-1:0] i_value,
    input  logic [CW-1:0]    i_channel,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [width:0]   o_value,
    output logic [CW-1:0]    o_channel
);

    localparam int unsigned OW = width + 1;

    logic [NW-1:0]    cnt_q [channels];
    logic [width-1:0] min_q [channels];
    logic [width-1:0] max_q [channels];

    logic             ch_ok;
    logic             upd;
    logic             first;
    logic             last;
    logic             take_min;
    logic             take_max;
    logic [CW-1:0]    idx;
    logic [width-1:0] cur_min;
    logic [width-1:0] cur_max;
    logic [width-1:0] new_min;
    logic [width-1:0] new_max;
    logic [OW-1:0]    diff;

    assign i_ready = !o_valid || o_ready;

    // Out-of-range channels complete the handshake but never touch state; idx is clamped so it stays in bounds.
    always_comb begin
        ch_ok    = 32'(i_channel) < channels;
        idx      = ch_ok ? i_channel : '0;
        upd      = i_valid && i_ready && ch_ok;
        cur_min  = min_q[idx];
        cur_max  = max_q[idx];
        first    = cnt_q[idx] == '0;
        last     = cnt_q[idx] == NW'(sample_count - 1);
`ifdef SECTION_PEAK_TO_PEAK_SIGNED_EN
        take_min = $signed(i_value) < $signed(cur_min);
        take_max = $signed(i_value) > $signed(cur_max);
`else
        take_min = i_value < cur_min;
        take_max = i_value > cur_max;
`endif
        new_min  = (first || take_min) ? i_value : cur_min;
        new_max  = (first || take_max) ? i_value : cur_max;
`ifdef SECTION_PEAK_TO_PEAK_SIGNED_EN
        diff     = {new_max[width-1], new_max} - {new_min[width-1], new_min};
`else
        diff     = {1'b0, new_max} - {1'b0, new_min};
`endif
    end

    // Per-channel position within the current section.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < int'(channels); c++) begin
                cnt_q[c] <= '0;
            end
        end else if (upd) begin
            cnt_q[idx] <= last ? '0 : cnt_q[idx] + NW'(1);
        end
    end

    // Extremes need no reset: a zero count forces a reload on the next sample.
    always_ff @(posedge clk) begin
        if (upd) begin
            min_q[idx] <= new_min;
            max_q[idx] <= new_max;
        end
    end

    // Single output register; a completion on a transfer edge reloads it with no bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_valid   <= 1'b0;
            o_value   <= '0;
            o_channel <= '0;
        end else if (upd && last) begin
            o_valid   <= 1'b1;
            o_value   <= diff;
            o_channel <= idx;
        end else if (o_ready) begin
            o_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_section_peak_to_peak.sv
// Scoreboard bench for section_peak_to_peak: directed stimulus pushes expectations, a monitor pops on each output transfer.
module tb_section_peak_to_peak;

    typedef struct {
        logic [16:0] value;
        logic [1:0]  ch;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        i_valid;
    logic        i_ready;
    logic [15:0] i_value;
    logic [0:0]  i_channel;
    logic        o_valid;
    logic        o_ready;
    logic [16:0] o_value;
    logic [0:0]  o_channel;

    logic        i_valid3;
    logic        i_ready3;
    logic [15:0] i_value3;
    logic [1:0]  i_channel3;
    logic        o_valid3;
    logic        o_ready3;
    logic [16:0] o_value3;
    logic [1:0]  o_channel3;

    exp_t q[$];
    exp_t q3[$];
    int   checks   = 0;
    int   failures = 0;

    section_peak_to_peak #(.width(16), .sample_count(3), .channels(2)) u_dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_ready(i_ready), .i_value(i_value), .i_channel(i_channel),
        .o_valid(o_valid), .o_ready(o_ready), .o_value(o_value), .o_channel(o_channel)
    );

    // Three channels so that index 3 is representable and out of range.
    section_peak_to_peak #(.width(16), .sample_count(3), .channels(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .i_valid(i_valid3), .i_ready(i_ready3), .i_value(i_value3), .i_channel(i_channel3),
        .o_valid(o_valid3), .o_ready(o_ready3), .o_value(o_value3), .o_channel(o_channel3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every output transfer must match the head of its expectation queue.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && o_valid && o_ready) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL out_unexpected got value=%h ch=%0d required no output", o_value, o_channel);
            end else begin
                e = q.pop_front();
                if (o_value !== e.value || 2'(o_channel) !== e.ch) begin
                    failures++;
                    $display("FAIL out_result got value=%h ch=%0d required value=%h ch=%0d",
                             o_value, o_channel, e.value, e.ch);
                end
            end
        end
        if (!reset && o_valid3 && o_ready3) begin
            checks++;
            if (q3.size() == 0) begin
                failures++;
                $display("FAIL out3_unexpected got value=%h ch=%0d required no output", o_value3, o_channel3);
            end else begin
                e = q3.pop_front();
                if (o_value3 !== e.value || o_channel3 !== e.ch) begin
                    failures++;
                    $display("FAIL out3_result got value=%h ch=%0d required value=%h ch=%0d",
                             o_value3, o_channel3, e.value, e.ch);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got %h required %h", name, act, req);
        end
    endtask

    task automatic expect_out(input logic [16:0] v, input logic [1:0] ch);
        exp_t e;
        e.value = v;
        e.ch    = ch;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one sample and returns 1 time unit after the edge that accepts it.
    task automatic send(input logic [0:0] ch, input logic [15:0] v);
        bit acc = 0;
        i_valid   = 1'b1;
        i_channel = ch;
        i_value   = v;
        for (int k = 0; k < 100 && !acc; k++) begin
            @(negedge clk);
            if (i_ready) begin
                acc = 1;
                @(posedge clk);
                #1;
            end
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout got no accept required accept ch=%0d value=%h", ch, v);
        end
        i_valid = 1'b0;
    endtask

    task automatic send3(input logic [1:0] ch, input logic [15:0] v);
        bit acc = 0;
        i_valid3   = 1'b1;
        i_channel3 = ch;
        i_value3   = v;
        for (int k = 0; k < 100 && !acc; k++) begin
            @(negedge clk);
            if (i_ready3) begin
                acc = 1;
                @(posedge clk);
                #1;
            end
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send3_timeout got no accept required accept ch=%0d value=%h", ch, v);
        end
        i_valid3 = 1'b0;
    endtask

    initial begin
        exp_t e;
        reset      = 1'b0;
        i_valid    = 1'b0;
        i_value    = '0;
        i_channel  = '0;
        o_ready    = 1'b1;
        i_valid3   = 1'b0;
        i_value3   = '0;
        i_channel3 = '0;
        o_ready3   = 1'b1;

        // Reset asserted between edges
        #12 reset = 1'b1;
        #1;
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        chk("rst_o_value", 32'(o_value), 32'd0);
        chk("rst_o_channel", 32'(o_channel), 32'd0);
        chk("rst_i_ready", 32'(i_ready), 32'd1);
        @(negedge clk) reset = 1'b0;
        idle(1);

        // Single channel
        send(1'b0, 16'h1111);
        send(1'b0, 16'h4444);
        expect_out(17'h03333, 2'd0);
        send(1'b0, 16'h2222);
        chk("single_valid_hi", 32'(o_valid), 32'd1);
        idle(1);
        chk("single_valid_lo", 32'(o_valid), 32'd0);
        idle(2);

        // Interleaved channels
        send(1'b0, 16'h6666);
        send(1'b1, 16'h1000);
        send(1'b0, 16'h1111);
        send(1'b1, 16'h1000);
        expect_out(17'h05555, 2'd0);
        send(1'b0, 16'h2222);
        expect_out(17'h00000, 2'd1);
        send(1'b1, 16'h1000);
        idle(3);

        // Backpressure
        o_ready = 1'b0;
        send(1'b0, 16'h0000);
        send(1'b0, 16'h0000);
        expect_out(17'h00000, 2'd0);
        send(1'b0, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            chk("bp_o_valid", 32'(o_valid), 32'd1);
            chk("bp_o_value", 32'(o_value), 32'd0);
            chk("bp_i_ready", 32'(i_ready), 32'd0);
            i_valid   = 1'b1;
            i_channel = 1'b0;
            i_value   = 16'hFFFF;
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        o_ready = 1'b1;
        idle(1);
        chk("bp_release_i_ready", 32'(i_ready), 32'd1);
        chk("bp_release_o_valid", 32'(o_valid), 32'd0);
        send(1'b0, 16'h0100);
        send(1'b0, 16'h0100);
        expect_out(17'h00000, 2'd0);
        send(1'b0, 16'h0100);
        idle(3);

        // Reset mid-section with a pending output
        o_ready = 1'b0;
        send(1'b0, 16'hFFFF);
        send(1'b0, 16'h0000);
        send(1'b1, 16'h0001);
        send(1'b1, 16'h0005);
        send(1'b1, 16'h0003);
        chk("pend_o_value", 32'(o_value), 32'h4);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_o_valid", 32'(o_valid), 32'd0);
        chk("mid_rst_o_value", 32'(o_value), 32'd0);
        chk("mid_rst_o_channel", 32'(o_channel), 32'd0);
        chk("mid_rst_i_ready", 32'(i_ready), 32'd1);
        @(negedge clk) reset = 1'b0;
        o_ready = 1'b1;
        idle(1);
        send(1'b0, 16'h1111);
        send(1'b0, 16'h1111);
        expect_out(17'h00000, 2'd0);
        send(1'b0, 16'h1111);
        idle(3);

        // Signed vs unsigned comparison
        send(1'b0, 16'h8000);
        send(1'b0, 16'h7FFF);
`ifdef SECTION_PEAK_TO_PEAK_SIGNED_EN
        expect_out(17'h0FFFF, 2'd0);
`else
        expect_out(17'h00001, 2'd0);
`endif
        send(1'b0, 16'h7FFF);
        idle(3);

        // Out-of-range channel on the three-channel instance
        send3(2'd3, 16'hFFFF);
        idle(3);
        chk("oor_no_output", 32'(o_valid3), 32'd0);
        send3(2'd2, 16'h0010);
        send3(2'd3, 16'h0000);
        send3(2'd2, 16'h0030);
        e.value = 17'h00020;
        e.ch    = 2'd2;
        q3.push_back(e);
        send3(2'd2, 16'h0020);

        for (int k = 0; k < 50 && (q.size() != 0 || q3.size() != 0); k++) idle(1);
        idle(2);
        chk("drain_q", 32'(q.size()), 32'd0);
        chk("drain_q3", 32'(q3.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
